// File: rtl/arb4_grant_ctrl.sv
// 4-requester arbiter: fixed priority (bit 3 highest) with per-owner hold timeout and global enable.
// Define ARB_ROUND_ROBIN_EN to rotate the search order below the last winner.
module arb4_grant_ctrl #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] Y,
    output logic       V
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

    state_t            state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        y_q, y_d;
    logic              v_q, v_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]        mask_q, mask_d;

    logic [3:0]        elig;
    logic [1:0]        winner;
    logic              found;

    assign elig = req & ~mask_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    // Search p-1, p-2, p-3, p; the first eligible index found wins.
    always_comb begin
        logic [1:0] idx;
        winner = 2'd0;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q - 2'(k);
            if (!found && elig[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (elig[k]) begin
                winner = 2'(k);
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        y_d        = y_q;
        v_d        = v_q;
        hold_cnt_d = hold_cnt_q;
        mask_d     = mask_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (E && found) begin
                    state_d    = GRANT;
                    gnt_d      = 4'b0001 << winner;
                    y_d        = winner;
                    v_d        = 1'b1;
                    hold_cnt_d = '0;
                    mask_d     = 4'b0000;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d      = winner;
`endif
                end else if (elig == 4'b0000) begin
                    // Nothing eligible: drop the mask so a lone timed-out requester can return.
                    mask_d = 4'b0000;
                end
            end
            GRANT: begin
                if (!E || !req[y_q]) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    y_d     = 2'd0;
                    v_d     = 1'b0;
                end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST) begin
                    state_d     = IDLE;
                    gnt_d       = 4'b0000;
                    y_d         = 2'd0;
                    v_d         = 1'b0;
                    mask_d[y_q] = 1'b1;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                y_d     = 2'd0;
                v_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            y_q        <= 2'd0;
            v_q        <= 1'b0;
            hold_cnt_q <= '0;
            mask_q     <= 4'b0000;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q      <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            y_q        <= y_d;
            v_q        <= v_d;
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign gnt = gnt_q;
    assign Y   = y_q;
    assign V   = v_q;

endmodule

// File: tb/tb_arb4_grant_ctrl.sv
// Directed self-checking bench for arb4_grant_ctrl (default MAX_HOLD=8).
module tb_arb4_grant_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       E;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] Y;
    logic       V;

    int tests_run = 0;
    int tests_failed = 0;
    logic [6:0] exp_out;

    arb4_grant_ctrl #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .E   (E),
        .req (req),
        .gnt (gnt),
        .Y   (Y),
        .V   (V)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            tests_run++;
            if (!$onehot0(gnt) || (V !== |gnt) ||
                (V && (gnt !== (4'b0001 << Y))) || (!V && Y !== 2'd0)) begin
                tests_failed++;
                $display("FAIL invariant: gnt=%b Y=%0d V=%b", gnt, Y, V);
            end
        end
    end

    task automatic go_idle();
        req = 4'b0000;
        E   = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; E = 1'b1; req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if ({gnt, Y, V} !== 7'b0000_00_0) begin
                tests_failed++;
                $display("FAIL reset_hold%0d: got gnt=%b Y=%0d V=%b, want 0000/0/0", i, gnt, Y, V);
            end
            $display("[TB] reset cycle %0d gnt=%b Y=%0d V=%b", i, gnt, Y, V);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({gnt, Y, V} !== 7'b1000_11_1) begin
            tests_failed++;
            $display("FAIL reset_first_grant: got gnt=%b Y=%0d V=%b, want 1000/3/1", gnt, Y, V);
        end
        $display("[TB] first grant gnt=%b Y=%0d V=%b", gnt, Y, V);
        go_idle();
    endtask

    task automatic test_priority();
        logic [3:0] reqs [3] = '{4'b0110, 4'b0010, 4'b0010};
        logic [6:0] exps [3] = '{7'b0100_10_1, 7'b0000_00_0, 7'b0010_01_1};
        for (int i = 0; i < 3; i++) begin
            req = reqs[i];
            tick();
            tests_run++;
            if ({gnt, Y, V} !== exps[i]) begin
                tests_failed++;
                $display("FAIL priority_%0d: got %b/%0d/%b, want %b", i, gnt, Y, V, exps[i]);
            end
            $display("[TB] priority req=%b gnt=%b Y=%0d V=%b", req, gnt, Y, V);
        end
        go_idle();
    endtask

    task automatic test_enable();
        E = 1'b0; req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (V !== 1'b0) begin
                tests_failed++;
                $display("FAIL enable_block%0d: got V=%b, want 0", i, V);
            end
        end
        E = 1'b1;
        tick();
        tests_run++;
        if ({gnt, Y, V} !== 7'b0001_00_1) begin
            tests_failed++;
            $display("FAIL enable_grant: got %b/%0d/%b, want 0001/0/1", gnt, Y, V);
        end
        $display("[TB] enable grant gnt=%b V=%b", gnt, V);
        E = 1'b0;
        tick();
        tests_run++;
        if ({gnt, Y, V} !== 7'b0000_00_0) begin
            tests_failed++;
            $display("FAIL enable_release: got %b/%0d/%b, want 0000/0/0", gnt, Y, V);
        end
        $display("[TB] enable release gnt=%b V=%b", gnt, V);
        go_idle();
    endtask

    task automatic test_timeout();
        req = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if ({gnt, Y, V} !== 7'b1000_11_1) begin
                tests_failed++;
                $display("FAIL timeout_hold%0d: got %b/%0d/%b, want 1000/3/1", i, gnt, Y, V);
            end
        end
        tick();
        tests_run++;
        if (V !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_release: got V=%b gnt=%b, want V=0", V, gnt);
        end
        tick();
        tests_run++;
        if ({gnt, Y, V} !== 7'b0001_00_1) begin
            tests_failed++;
            $display("FAIL timeout_masked_winner: got %b/%0d/%b, want 0001/0/1", gnt, Y, V);
        end
        $display("[TB] timeout handover gnt=%b Y=%0d", gnt, Y);
        req = 4'b1000;
        tick();
        tests_run++;
        if (V !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_r0_release: got V=%b, want 0", V);
        end
        tick();
        tests_run++;
        if ({gnt, Y, V} !== 7'b1000_11_1) begin
            tests_failed++;
            $display("FAIL timeout_regrant3: got %b/%0d/%b, want 1000/3/1", gnt, Y, V);
        end
        // Lone requester: times out again, then waits two idle cycles before re-grant.
        for (int i = 0; i < 7; i++) tick();
        tests_run++;
        if (gnt !== 4'b1000) begin
            tests_failed++;
            $display("FAIL lone_hold_end: got gnt=%b, want 1000", gnt);
        end
        exp_out = 7'b0000_00_0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if ({gnt, Y, V} !== exp_out) begin
                tests_failed++;
                $display("FAIL lone_gap%0d: got %b/%0d/%b, want idle", i, gnt, Y, V);
            end
        end
        tick();
        tests_run++;
        if ({gnt, Y, V} !== 7'b1000_11_1) begin
            tests_failed++;
            $display("FAIL lone_regrant: got %b/%0d/%b, want 1000/3/1", gnt, Y, V);
        end
        $display("[TB] lone requester regrant gnt=%b", gnt);
        go_idle();
    endtask

    task automatic test_rotation();
`ifdef ARB_ROUND_ROBIN_EN
        logic [1:0] seq [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
        logic [1:0] seq [5] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        // Reset so the rotation pointer starts from 0.
        rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req = 4'b1111;
            tick();
            tests_run++;
            if ({V, Y} !== {1'b1, seq[i]}) begin
                tests_failed++;
                $display("FAIL rotation_%0d: got V=%b Y=%0d, want V=1 Y=%0d", i, V, Y, seq[i]);
            end
            $display("[TB] rotation step %0d owner=%0d", i, Y);
            req = 4'b1111 & ~(4'b0001 << seq[i]);
            tick();
            tests_run++;
            if (V !== 1'b0) begin
                tests_failed++;
                $display("FAIL rotation_gap%0d: got V=%b, want 0", i, V);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b0100;
        tick();
        tests_run++;
        if ({gnt, Y, V} !== 7'b0100_10_1) begin
            tests_failed++;
            $display("FAIL midrst_grant: got %b/%0d/%b, want 0100/2/1", gnt, Y, V);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if ({gnt, Y, V} !== 7'b0000_00_0) begin
            tests_failed++;
            $display("FAIL midrst_drop: got %b/%0d/%b, want 0000/0/0", gnt, Y, V);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({gnt, Y, V} !== 7'b0100_10_1) begin
            tests_failed++;
            $display("FAIL midrst_regrant: got %b/%0d/%b, want 0100/2/1", gnt, Y, V);
        end
        $display("[TB] reset mid-grant regrant gnt=%b", gnt);
        go_idle();
    endtask

    initial begin
        rst = 1'b1; E = 1'b1; req = 4'b0000;
        test_reset();
        test_priority();
        test_enable();
        test_timeout();
        test_rotation();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
